// File: rtl/ula_mc.sv
// ula_mc: multi-cycle ALU for the execute stage with a start/busy/done handshake.
// Ports: clk, rst, start, OP, ln1, ln2 -> busy, done, result, hi, Zero_flag.
module ula_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] ln1,
  input  logic [WIDTH-1:0] ln2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             Zero_flag
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  localparam logic [SHW:0] CNT_INIT = WIDTH[SHW:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [SHW:0]     cnt;
  logic             is_div;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   sh;
  logic             is_long;
  logic             accept;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] sub_rem;

  assign sh      = ln2[SHW-1:0];
  assign is_long = (OP == OP_MULTU) || (OP == OP_DIVU);
  assign accept  = start && (state != RUN);

  always_comb begin
    alu_res = '0;
    unique case (OP)
      OP_AND:  alu_res = ln1 & ln2;
      OP_OR:   alu_res = ln1 | ln2;
      OP_XOR:  alu_res = ln1 ^ ln2;
      OP_NOR:  alu_res = ~(ln1 | ln2);
      OP_ADD:  alu_res = ln1 + ln2;
      OP_SUB:  alu_res = ln1 - ln2;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ln1 < ln2};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(ln1) < $signed(ln2)};
      OP_SLL:  alu_res = ln1 << sh;
      OP_SRL:  alu_res = ln1 >> sh;
      OP_SRA:  alu_res = $unsigned($signed(ln1) >>> sh);
      default: alu_res = '0;
    endcase
  end

  // Multiply: {acc,lo} shifts right, multiplier bits consumed from lo[0].
  // Divide: {acc,lo} shifts left, quotient bits enter at lo[0].
  assign add_sum = {1'b0, acc} + {1'b0, (lo[0] ? opnd : '0)};
  assign shifted = {acc, lo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, opnd};
  assign sub_rem = shifted[WIDTH-1:0] - opnd;

  always_comb begin
    acc_nx = add_sum[WIDTH:1];
    lo_nx  = {add_sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      if (ge) begin
        acc_nx = sub_rem;
        lo_nx  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shifted[WIDTH-1:0];
        lo_nx  = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nx = is_long ? RUN : DONE;
        else       state_nx = IDLE;
      end
      RUN:     if (cnt == 1) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      lo     <= '0;
      result <= '0;
      hi     <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      lo  <= lo_nx;
      cnt <= cnt - 1'b1;
      if (cnt == 1) begin
        result <= lo_nx;
        hi     <= acc_nx;
      end
    end else if (accept) begin
      if (is_long) begin
        is_div <= (OP == OP_DIVU);
        cnt    <= CNT_INIT;
        acc    <= '0;
        if (OP == OP_DIVU) begin
          opnd <= ln2;
          lo   <= ln1;
        end else begin
          opnd <= ln1;
          lo   <= ln2;
        end
      end else begin
        result <= alu_res;
        hi     <= '0;
      end
    end
  end

  assign Zero_flag = (result == '0);

endmodule

// File: tb/tb_ula_mc.sv
// tb_ula_mc: scoreboard bench for ula_mc.
// Driver pushes expected results; monitor pops on each done pulse.
module tb_ula_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  OP;
  logic [31:0] ln1, ln2;
  logic        busy, done, Zero_flag;
  logic [31:0] result, hi;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zf;
  } exp_t;

  exp_t sb[$];

  ula_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .OP(OP),
    .ln1(ln1), .ln2(ln2), .busy(busy), .done(done),
    .result(result), .hi(hi), .Zero_flag(Zero_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h, no entry", result);
      end else begin
        e = sb.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_hi", hi, e.hi);
        chk("sb_zf", {31'b0, Zero_flag}, {31'b0, e.zf});
      end
    end
  end

  task automatic push(input logic [31:0] r, input logic [31:0] h);
    exp_t e;
    e.res = r;
    e.hi  = h;
    e.zf  = (r == 32'h0);
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    OP    = op;
    ln1   = a;
    ln2   = b;
  endtask

  // Issue one op and wait for done; lat is the expected done cycle.
  task automatic issue(input string nm, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] eh,
                       input int lat);
    int cyc;
    int nbusy;
    @(negedge clk);
    drive(op, a, b);
    push(er, eh);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (!done && cyc < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_lat"}, cyc, lat);
    chk({nm, "_busy"}, nbusy, (lat > 1) ? lat - 1 : 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    OP    = 4'h0;
    ln1   = '0;
    ln2   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_zf", {31'b0, Zero_flag}, 32'd1);
    rst = 1'b0;

    // Back-to-back ADD then SUB with start held high.
    @(negedge clk);
    drive(4'b0101, 32'hFFFF_FFFF, 32'h1);
    push(32'h0, 32'h0);
    @(negedge clk);
    chk("b2b_done1", {31'b0, done}, 32'd1);
    drive(4'b0110, 32'd5, 32'd5);
    push(32'h0, 32'h0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", {31'b0, done}, 32'd1);

    issue("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 1);
    issue("or", 4'b0001, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 0, 1);
    issue("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0, 1);
    issue("nor", 4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 0, 1);
    issue("slt", 4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1);
    issue("sltu", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1);
    issue("sra", 4'b1011, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1);
    issue("srl", 4'b1010, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 1);
    issue("sll", 4'b1001, 32'h0000_0003, 32'h1F, 32'h8000_0000, 0, 1);

    // MULTU with an ignored ADD start pulse in cycle 10.
    begin
      int cyc;
      int nbusy;
      @(negedge clk);
      drive(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      push(32'h0000_0001, 32'hFFFF_FFFE);
      @(negedge clk);
      start = 1'b0;
      ln1   = 32'h0;
      ln2   = 32'h0;
      cyc   = 1;
      nbusy = 0;
      while (!done && cyc < 100) begin
        if (busy) nbusy++;
        if (cyc == 9) drive(4'b0101, 32'd7, 32'd8);
        else start = 1'b0;
        @(negedge clk);
        cyc++;
      end
      chk("mul_lat", cyc, 33);
      chk("mul_busy", nbusy, 32);
    end

    issue("divu", 4'b1101, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    issue("div0", 4'b1101, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 33);
    chk("div0_zf", {31'b0, Zero_flag}, 32'd0);

    // Reset in cycle 15 of a DIVU: aborted, no done, no scoreboard entry.
    @(negedge clk);
    drive(4'b1101, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_hi", hi, 32'd0);
    rst = 1'b0;

    issue("mul_fresh", 4'b1100, 32'd3, 32'd5, 32'd15, 32'd0, 33);
    issue("undef", 4'b0010, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 1);

    // Held values between done pulses.
    repeat (3) @(negedge clk);
    chk("hold_result", result, 32'h0);
    chk("hold_done", {31'b0, done}, 32'd0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, errors=%0d", errors);
    $fatal(1);
  end

endmodule
